// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the dual-port memory slice.
//   - state_e     : clear-engine FSM states (CLEAR, READY)
//   - DEF_*       : default parameter values used by mem_dual_port / mem_rd_pipe
//   - byte_parity : even-parity bit for one byte (used when MEM_PARITY_EN is defined)
package mem_pkg;

    localparam int unsigned DEF_WIDTH      = 32;
    localparam int unsigned DEF_DEPTH      = 256;
    localparam int unsigned DEF_ADD_WIDTH  = 8;
    localparam int unsigned DEF_RD_LATENCY = 1;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_e;

    // Even parity: the stored bit makes the total count of ones even.
    function automatic logic byte_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/mem_rd_pipe.sv
// mem_rd_pipe: RD_LATENCY-deep delay line for one read port.
// Carries read data, its valid flag and its parity-error flag in lockstep.
// Legal RD_LATENCY values are 1 and 2.
// Ports:
//   clk_i   clock, rising edge
//   rst_ni  asynchronous active-low reset (clears every stage)
//   vld_i   read accepted this cycle
//   data_i  read data captured this cycle (already 0 for ignored reads)
//   perr_i  parity mismatch observed on the captured word
//   vld_o   read valid, RD_LATENCY cycles after vld_i
//   data_o  read data aligned with vld_o
//   perr_o  parity error aligned with vld_o
module mem_rd_pipe
    import mem_pkg::*;
#(
    parameter int unsigned WIDTH      = DEF_WIDTH,
    parameter int unsigned RD_LATENCY = DEF_RD_LATENCY
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             vld_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             perr_i,
    output logic             vld_o,
    output logic [WIDTH-1:0] data_o,
    output logic             perr_o
);

    logic [WIDTH-1:0]      data_q [RD_LATENCY];
    logic [RD_LATENCY-1:0] vld_q;
    logic [RD_LATENCY-1:0] perr_q;

    // Stages advance every cycle regardless of the controller state, so a
    // read accepted just before a clear starts still reaches the output.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q  <= '0;
            perr_q <= '0;
            for (int unsigned i = 0; i < RD_LATENCY; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            vld_q[0]  <= vld_i;
            perr_q[0] <= perr_i & vld_i;
            data_q[0] <= data_i;
            for (int unsigned i = 1; i < RD_LATENCY; i++) begin
                vld_q[i]  <= vld_q[i-1];
                perr_q[i] <= perr_q[i-1];
                data_q[i] <= data_q[i-1];
            end
        end
    end

    assign vld_o  = vld_q[RD_LATENCY-1];
    assign perr_o = perr_q[RD_LATENCY-1];
    assign data_o = data_q[RD_LATENCY-1];

endmodule

// File: rtl/mem_dual_port.sv
// mem_dual_port: true dual-port RAM with byte enables, read-old-data
// semantics, a built-in clear engine and optional per-byte parity.
// Optional feature macro: MEM_PARITY_EN (adds one even-parity bit per byte).
// Ports:
//   clk       clock, rising edge
//   rst       asynchronous active-low reset
//   clr_req   one-cycle pulse requesting a full memory clear
//   busy      high while the clear engine runs (accesses ignored)
//   a_addr / a_wdata / a_be / a_wr_en / a_rd_en   port A request
//   a_rdata / a_rvalid                            port A read response
//   b_*       identical set for port B
//   coll      pulses the cycle after both ports write the same address
//   perr      parity error, bit0 port A, bit1 port B (aligned with rvalid)
module mem_dual_port
    import mem_pkg::*;
#(
    parameter int unsigned WIDTH      = DEF_WIDTH,
    parameter int unsigned DEPTH      = DEF_DEPTH,
    parameter int unsigned ADD_WIDTH  = DEF_ADD_WIDTH,
    parameter int unsigned RD_LATENCY = DEF_RD_LATENCY
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr_req,
    output logic                 busy,
    input  logic [ADD_WIDTH-1:0] a_addr,
    input  logic [WIDTH-1:0]     a_wdata,
    input  logic [WIDTH/8-1:0]   a_be,
    input  logic                 a_wr_en,
    input  logic                 a_rd_en,
    output logic [WIDTH-1:0]     a_rdata,
    output logic                 a_rvalid,
    input  logic [ADD_WIDTH-1:0] b_addr,
    input  logic [WIDTH-1:0]     b_wdata,
    input  logic [WIDTH/8-1:0]   b_be,
    input  logic                 b_wr_en,
    input  logic                 b_rd_en,
    output logic [WIDTH-1:0]     b_rdata,
    output logic                 b_rvalid,
    output logic                 coll,
    output logic [1:0]           perr
);

    localparam int unsigned          NB        = WIDTH / 8;
    localparam logic [ADD_WIDTH:0]   DEPTH_W   = (ADD_WIDTH + 1)'(DEPTH);
    localparam logic [ADD_WIDTH-1:0] LAST_ADDR = ADD_WIDTH'(DEPTH - 1);

    // ---------------------------------------------------------------
    // Clear-engine FSM
    // ---------------------------------------------------------------
    state_e               state_q, state_d;
    logic [ADD_WIDTH-1:0] clr_addr_q, clr_addr_d;
    logic                 clr_we;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= CLEAR;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        unique case (state_q)
            CLEAR: begin
                if (clr_req) begin
                    clr_addr_d = '0;          // restart the sweep
                end else if (clr_addr_q == LAST_ADDR) begin
                    state_d    = READY;
                    clr_addr_d = '0;
                end else begin
                    clr_addr_d = clr_addr_q + 1'b1;
                end
            end
            READY: begin
                if (clr_req) begin
                    state_d    = CLEAR;
                    clr_addr_d = '0;
                end
            end
        endcase
    end

    always_comb begin
        busy   = (state_q == CLEAR);
        clr_we = (state_q == CLEAR);
    end

    // ---------------------------------------------------------------
    // Access qualification
    // ---------------------------------------------------------------
    logic ready, a_in, b_in, a_we, b_we, a_re, b_re;

    assign ready = (state_q == READY);
    assign a_in  = ({1'b0, a_addr} < DEPTH_W);
    assign b_in  = ({1'b0, b_addr} < DEPTH_W);
    assign a_we  = ready & a_wr_en & a_in;
    assign b_we  = ready & b_wr_en & b_in;
    // Out-of-range reads are still acknowledged, with zero data.
    assign a_re  = ready & a_rd_en;
    assign b_re  = ready & b_rd_en;

    // ---------------------------------------------------------------
    // Storage (not reset; only the clear engine initialises it)
    // ---------------------------------------------------------------
    logic [WIDTH-1:0] mem_q [0:DEPTH-1];
`ifdef MEM_PARITY_EN
    logic [NB-1:0]    par_q [0:DEPTH-1];
`endif

    // Port B bytes are written first so that port A's assignment to the
    // same byte takes precedence on a collision.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem_q[clr_addr_q] <= '0;
`ifdef MEM_PARITY_EN
            par_q[clr_addr_q] <= {NB{byte_parity(8'h00)}};
`endif
        end else begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (b_we && b_be[i]) begin
                    mem_q[b_addr][8*i +: 8] <= b_wdata[8*i +: 8];
`ifdef MEM_PARITY_EN
                    par_q[b_addr][i] <= byte_parity(b_wdata[8*i +: 8]);
`endif
                end
            end
            for (int unsigned i = 0; i < NB; i++) begin
                if (a_we && a_be[i]) begin
                    mem_q[a_addr][8*i +: 8] <= a_wdata[8*i +: 8];
`ifdef MEM_PARITY_EN
                    par_q[a_addr][i] <= byte_parity(a_wdata[8*i +: 8]);
`endif
                end
            end
        end
    end

    // ---------------------------------------------------------------
    // Read capture: the array is sampled before this edge's writes land,
    // which gives read-old-data on any same-address read/write.
    // ---------------------------------------------------------------
    logic [WIDTH-1:0] a_rd_data, b_rd_data;
    logic             a_rd_perr, b_rd_perr;

    always_comb begin
        a_rd_data = '0;
        b_rd_data = '0;
        if (a_re && a_in) a_rd_data = mem_q[a_addr];
        if (b_re && b_in) b_rd_data = mem_q[b_addr];
    end

`ifdef MEM_PARITY_EN
    always_comb begin
        a_rd_perr = 1'b0;
        b_rd_perr = 1'b0;
        for (int unsigned i = 0; i < NB; i++) begin
            if (a_re && a_in &&
                (byte_parity(mem_q[a_addr][8*i +: 8]) != par_q[a_addr][i]))
                a_rd_perr = 1'b1;
            if (b_re && b_in &&
                (byte_parity(mem_q[b_addr][8*i +: 8]) != par_q[b_addr][i]))
                b_rd_perr = 1'b1;
        end
    end
`else
    assign a_rd_perr = 1'b0;
    assign b_rd_perr = 1'b0;
`endif

    // ---------------------------------------------------------------
    // Collision flag
    // ---------------------------------------------------------------
    logic coll_q, coll_d;

    assign coll_d = a_we & b_we & (a_addr == b_addr);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) coll_q <= 1'b0;
        else      coll_q <= coll_d;
    end

    assign coll = coll_q;

    // ---------------------------------------------------------------
    // Read response pipelines
    // ---------------------------------------------------------------
    mem_rd_pipe #(
        .WIDTH      (WIDTH),
        .RD_LATENCY (RD_LATENCY)
    ) u_rd_pipe_a (
        .clk_i  (clk),
        .rst_ni (rst),
        .vld_i  (a_re),
        .data_i (a_rd_data),
        .perr_i (a_rd_perr),
        .vld_o  (a_rvalid),
        .data_o (a_rdata),
        .perr_o (perr[0])
    );

    mem_rd_pipe #(
        .WIDTH      (WIDTH),
        .RD_LATENCY (RD_LATENCY)
    ) u_rd_pipe_b (
        .clk_i  (clk),
        .rst_ni (rst),
        .vld_i  (b_re),
        .data_i (b_rd_data),
        .perr_i (b_rd_perr),
        .vld_o  (b_rvalid),
        .data_o (b_rdata),
        .perr_o (perr[1])
    );

endmodule

// File: tb/tb_mem_dual_port.sv
// tb_mem_dual_port: directed self-checking bench for mem_dual_port.
// Main instance uses default parameters; a second small instance
// (WIDTH=16, DEPTH=12, ADD_WIDTH=4, RD_LATENCY=2) covers out-of-range
// addresses and two-cycle read latency.
// With MEM_PARITY_EN defined, a stored bit is flipped to provoke perr.
module tb_mem_dual_port;

    localparam int unsigned W  = 32;
    localparam int unsigned D  = 256;
    localparam int unsigned AW = 8;

    localparam int unsigned SW  = 16;
    localparam int unsigned SD  = 12;
    localparam int unsigned SAW = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // main instance signals
    logic          clr_req, busy, coll;
    logic [AW-1:0] a_addr, b_addr;
    logic [W-1:0]  a_wdata, b_wdata, a_rdata, b_rdata;
    logic [3:0]    a_be, b_be;
    logic          a_wr_en, b_wr_en, a_rd_en, b_rd_en, a_rvalid, b_rvalid;
    logic [1:0]    perr;

    // small instance signals
    logic           s_clr_req, s_busy, s_coll;
    logic [SAW-1:0] s_a_addr, s_b_addr;
    logic [SW-1:0]  s_a_wdata, s_b_wdata, s_a_rdata, s_b_rdata;
    logic [1:0]     s_a_be, s_b_be;
    logic           s_a_wr_en, s_b_wr_en, s_a_rd_en, s_b_rd_en;
    logic           s_a_rvalid, s_b_rvalid;
    logic [1:0]     s_perr;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    mem_dual_port #(
        .WIDTH      (W),
        .DEPTH      (D),
        .ADD_WIDTH  (AW),
        .RD_LATENCY (1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .clr_req  (clr_req),
        .busy     (busy),
        .a_addr   (a_addr),
        .a_wdata  (a_wdata),
        .a_be     (a_be),
        .a_wr_en  (a_wr_en),
        .a_rd_en  (a_rd_en),
        .a_rdata  (a_rdata),
        .a_rvalid (a_rvalid),
        .b_addr   (b_addr),
        .b_wdata  (b_wdata),
        .b_be     (b_be),
        .b_wr_en  (b_wr_en),
        .b_rd_en  (b_rd_en),
        .b_rdata  (b_rdata),
        .b_rvalid (b_rvalid),
        .coll     (coll),
        .perr     (perr)
    );

    mem_dual_port #(
        .WIDTH      (SW),
        .DEPTH      (SD),
        .ADD_WIDTH  (SAW),
        .RD_LATENCY (2)
    ) dut_s (
        .clk      (clk),
        .rst      (rst),
        .clr_req  (s_clr_req),
        .busy     (s_busy),
        .a_addr   (s_a_addr),
        .a_wdata  (s_a_wdata),
        .a_be     (s_a_be),
        .a_wr_en  (s_a_wr_en),
        .a_rd_en  (s_a_rd_en),
        .a_rdata  (s_a_rdata),
        .a_rvalid (s_a_rvalid),
        .b_addr   (s_b_addr),
        .b_wdata  (s_b_wdata),
        .b_be     (s_b_be),
        .b_wr_en  (s_b_wr_en),
        .b_rd_en  (s_b_rd_en),
        .b_rdata  (s_b_rdata),
        .b_rvalid (s_b_rvalid),
        .coll     (s_coll),
        .perr     (s_perr)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input bit pb, input logic [AW-1:0] addr, input logic [W-1:0] data,
                      input logic [3:0] be);
        if (!pb) begin a_addr = addr; a_wdata = data; a_be = be; a_wr_en = 1'b1; end
        else     begin b_addr = addr; b_wdata = data; b_be = be; b_wr_en = 1'b1; end
        tick();
        a_wr_en = 1'b0;
        b_wr_en = 1'b0;
    endtask

    task automatic rd(input bit pb, input logic [AW-1:0] addr, input logic [W-1:0] exp,
                      input string tag);
        if (!pb) begin a_addr = addr; a_rd_en = 1'b1; end
        else     begin b_addr = addr; b_rd_en = 1'b1; end
        tick();
        a_rd_en = 1'b0;
        b_rd_en = 1'b0;
        check({tag, "_vld"}, pb ? b_rvalid : a_rvalid, 1);
        check({tag, "_dat"}, pb ? b_rdata : a_rdata, exp);
        check({tag, "_perr"}, perr, 0);
        tick();
        check({tag, "_vld_off"}, pb ? b_rvalid : a_rvalid, 0);
    endtask

    task automatic s_wr(input bit pb, input logic [SAW-1:0] addr, input logic [SW-1:0] data,
                        input logic [1:0] be);
        if (!pb) begin s_a_addr = addr; s_a_wdata = data; s_a_be = be; s_a_wr_en = 1'b1; end
        else     begin s_b_addr = addr; s_b_wdata = data; s_b_be = be; s_b_wr_en = 1'b1; end
        tick();
        s_a_wr_en = 1'b0;
        s_b_wr_en = 1'b0;
    endtask

    // Two-cycle latency: nothing after the first edge, data after the second.
    task automatic s_rd(input bit pb, input logic [SAW-1:0] addr, input logic [SW-1:0] exp,
                        input string tag);
        if (!pb) begin s_a_addr = addr; s_a_rd_en = 1'b1; end
        else     begin s_b_addr = addr; s_b_rd_en = 1'b1; end
        tick();
        s_a_rd_en = 1'b0;
        s_b_rd_en = 1'b0;
        check({tag, "_early"}, pb ? s_b_rvalid : s_a_rvalid, 0);
        tick();
        check({tag, "_vld"}, pb ? s_b_rvalid : s_a_rvalid, 1);
        check({tag, "_dat"}, pb ? s_b_rdata : s_a_rdata, exp);
        tick();
        check({tag, "_vld_off"}, pb ? s_b_rvalid : s_a_rvalid, 0);
    endtask

    task automatic wait_ready(output int unsigned n);
        n = 0;
        while (busy && n < 1000) begin
            tick();
            n++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned n, s_n;

        rst = 1'b0;
        clr_req = 1'b0; a_addr = '0; a_wdata = '0; a_be = '0; a_wr_en = 1'b0;
        b_addr = '0; b_wdata = '0; b_be = '0; b_wr_en = 1'b0;
        s_clr_req = 1'b0; s_a_addr = '0; s_a_wdata = '0; s_a_be = '0; s_a_wr_en = 1'b0;
        s_b_addr = '0; s_b_wdata = '0; s_b_be = '0; s_b_wr_en = 1'b0;
        s_a_rd_en = 1'b0; s_b_rd_en = 1'b0;
        // read strobes held high during reset must not produce responses
        a_rd_en = 1'b1; b_rd_en = 1'b1;
        repeat (3) tick();
        check("rst_busy",   busy, 1);
        check("rst_a_rdat", a_rdata, 0);
        check("rst_a_vld",  a_rvalid, 0);
        check("rst_b_rdat", b_rdata, 0);
        check("rst_b_vld",  b_rvalid, 0);
        check("rst_coll",   coll, 0);
        check("rst_perr",   perr, 0);
        check("rst_s_busy", s_busy, 1);
        a_rd_en = 1'b0; b_rd_en = 1'b0;

        // release: main clears 256 words, small instance 12
        rst = 1'b1;
        n = 0; s_n = 0;
        while (busy && n < 1000) begin
            tick();
            n++;
            if (!s_busy && s_n == 0) s_n = n;
        end
        check("rel_busy_len",   n, 256);
        check("rel_s_busy_len", s_n, 12);

        // small instance: byte enables, out-of-range and last address
        s_wr(0, 4'd3, 16'hBEEF, 2'b11);
        s_wr(0, 4'd12, 16'hFFFF, 2'b11);
        s_wr(1, 4'd11, 16'hA5A5, 2'b01);
        s_wr(1, 4'd3, 16'h1234, 2'b10);
        s_rd(0, 4'd12, 16'h0000, "s_oob12");
        s_rd(1, 4'd3,  16'h12EF, "s_rd3");
        s_rd(0, 4'd11, 16'h00A5, "s_rd11");
        s_rd(1, 4'd15, 16'h0000, "s_oob15");

        // main: byte-enable merge across ports
        rd(0, 8'd0, 32'h0, "rd0_init");
        wr(0, 8'd5, 32'hDEADBEEF, 4'b1111);
        wr(1, 8'd5, 32'h00000011, 4'b0001);
        rd(0, 8'd5, 32'hDEADBE11, "be_merge_a");
        rd(1, 8'd5, 32'hDEADBE11, "be_merge_b");

        // same-address collision: A owns bytes 3 and 2, B byte 1
        a_addr = 8'd9; a_wdata = 32'hAAAAAAAA; a_be = 4'b1100; a_wr_en = 1'b1;
        b_addr = 8'd9; b_wdata = 32'h55555555; b_be = 4'b0110; b_wr_en = 1'b1;
        check("coll_pre", coll, 0);
        tick();
        a_wr_en = 1'b0; b_wr_en = 1'b0;
        check("coll_pulse", coll, 1);
        tick();
        check("coll_off", coll, 0);
        rd(0, 8'd9, 32'hAAAA5500, "coll_data");

        // different addresses in the same cycle: no collision
        a_addr = 8'd10; a_wdata = 32'h01020304; a_be = 4'b1111; a_wr_en = 1'b1;
        b_addr = 8'd11; b_wdata = 32'h0A0B0C0D; b_be = 4'b1111; b_wr_en = 1'b1;
        tick();
        a_wr_en = 1'b0; b_wr_en = 1'b0;
        check("nocoll", coll, 0);
        rd(1, 8'd10, 32'h01020304, "rd10");
        rd(0, 8'd11, 32'h0A0B0C0D, "rd11");

        // read-old-data, same port
        wr(0, 8'd3, 32'h1, 4'b1111);
        a_addr = 8'd3; a_wdata = 32'h2; a_be = 4'b1111; a_wr_en = 1'b1; a_rd_en = 1'b1;
        tick();
        a_wr_en = 1'b0; a_rd_en = 1'b0;
        check("raw_same_vld", a_rvalid, 1);
        check("raw_same_dat", a_rdata, 32'h1);
        tick();
        rd(0, 8'd3, 32'h2, "raw_same_new");

        // read-old-data, across ports; simultaneous reads on both ports
        a_addr = 8'd3; a_wdata = 32'h4; a_be = 4'b1111; a_wr_en = 1'b1;
        b_addr = 8'd3; b_rd_en = 1'b1;
        tick();
        a_wr_en = 1'b0; b_rd_en = 1'b0;
        check("raw_x_dat", b_rdata, 32'h2);
        tick();
        a_addr = 8'd5; a_rd_en = 1'b1;
        b_addr = 8'd3; b_rd_en = 1'b1;
        tick();
        a_rd_en = 1'b0; b_rd_en = 1'b0;
        check("dual_rd_a", a_rdata, 32'hDEADBE11);
        check("dual_rd_b", b_rdata, 32'h4);

        // top address
        wr(1, 8'd255, 32'h12345678, 4'b1111);
        rd(0, 8'd255, 32'h12345678, "rd255");

`ifdef MEM_PARITY_EN
        wr(0, 8'd7, 32'h0000000F, 4'b1111);
        dut.mem_q[7][0] = ~dut.mem_q[7][0];
        a_addr = 8'd7; a_rd_en = 1'b1;
        tick();
        a_rd_en = 1'b0;
        check("par_vld",  a_rvalid, 1);
        check("par_perr", perr, 2'b01);
        tick();
        check("par_perr_off", perr, 2'b00);
`endif

        // clear request, then restart mid-sweep; accesses ignored while busy
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        check("clr_busy", busy, 1);
        repeat (20) tick();
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        n = 0;
        repeat (5) begin tick(); n++; end
        a_addr = 8'd0; a_wdata = 32'hFFFFFFFF; a_be = 4'b1111; a_wr_en = 1'b1; a_rd_en = 1'b1;
        b_addr = 8'd0; b_wdata = 32'hFFFFFFFF; b_be = 4'b1111; b_wr_en = 1'b1;
        tick();
        n++;
        a_wr_en = 1'b0; a_rd_en = 1'b0; b_wr_en = 1'b0;
        check("busy_no_vld",  a_rvalid, 0);
        check("busy_no_coll", coll, 0);
        while (busy && n < 1000) begin tick(); n++; end
        check("restart_len", n, 256);
        rd(0, 8'd0,   32'h0, "clr_rd0");
        rd(0, 8'd5,   32'h0, "clr_rd5");
        rd(1, 8'd9,   32'h0, "clr_rd9");
        rd(1, 8'd255, 32'h0, "clr_rd255");

        // reset while a read response is on the output
        wr(0, 8'd5, 32'hCAFEF00D, 4'b1111);
        a_addr = 8'd5; a_rd_en = 1'b1;
        tick();
        a_rd_en = 1'b0;
        check("pre_rst_dat", a_rdata, 32'hCAFEF00D);
        rst = 1'b0;
        #1;
        check("mid_rst_dat",  a_rdata, 0);
        check("mid_rst_vld",  a_rvalid, 0);
        check("mid_rst_busy", busy, 1);
        repeat (2) tick();
        rst = 1'b1;
        wait_ready(n);
        check("rst2_len", n, 256);
        rd(0, 8'd5, 32'h0, "rst2_rd5");

        // clear requested after 100 idle cycles, reset 10 cycles later
        wr(1, 8'd20, 32'h87654321, 4'b1111);
        repeat (100) tick();
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        repeat (9) tick();
        rst = 1'b0;
        #1;
        check("rst3_busy", busy, 1);
        check("rst3_vld",  a_rvalid, 0);
        check("rst3_coll", coll, 0);
        check("rst3_perr", perr, 0);
        repeat (2) tick();
        rst = 1'b1;
        wait_ready(n);
        check("rst3_len", n, 256);
        rd(1, 8'd20, 32'h0, "rst3_rd20");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
